// File: rtl/pwm_gen_if.sv
// Duty/PWM signal bundle between a duty source (master) and the PWM generator (slave).
// The master drives the duty word; the generator returns the pulse train and period marker.
`timescale 1ns/1ps
interface pwm_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] inpt;
    logic             outp;
    logic             period_start;

    modport master (
        output inpt,
        input  outp,
        input  period_start
    );

    modport slave (
        input  inpt,
        output outp,
        output period_start
    );
endinterface

// File: rtl/pwm_gen.sv
// Free-running PWM generator: high for duty ticks out of each 2**WIDTH-tick period.
// Duty is latched at the first tick of each period so a period never mixes two duties.
`timescale 1ns/1ps
module pwm_gen #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    pwm_gen_if.slave   bus
);

    logic             tick;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] duty_reg;
    logic [WIDTH-1:0] duty_sel;
    logic             cnt_zero;
    logic             outp_reg;
    logic             period_start_reg;

    generate
        if (PRESCALE <= 1) begin : g_no_prescale
            assign tick = 1'b1;
        end else begin : g_prescale
            localparam int PS_W = $clog2(PRESCALE);
            localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
            logic [PS_W-1:0] pre_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pre_reg <= '0;
                end else if (pre_reg == PS_LAST) begin
                    pre_reg <= '0;
                end else begin
                    pre_reg <= pre_reg + PS_W'(1);
                end
            end

            assign tick = (pre_reg == PS_LAST);
        end
    endgenerate

    // At cnt==0 the live input is used directly, so the first sample of a period
    // already reflects the duty that is being latched on that same tick.
    assign cnt_zero = (cnt_reg == '0);
    assign duty_sel = cnt_zero ? bus.inpt : duty_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg          <= '0;
            duty_reg         <= '0;
            outp_reg         <= 1'b0;
            period_start_reg <= 1'b0;
        end else if (tick) begin
            cnt_reg          <= cnt_reg + WIDTH'(1);
            outp_reg         <= (cnt_reg < duty_sel);
            period_start_reg <= cnt_zero;
            if (cnt_zero) begin
                duty_reg <= bus.inpt;
            end
        end else begin
            period_start_reg <= 1'b0;
        end
    end

    assign bus.outp         = outp_reg;
    assign bus.period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: per-period high-time and period-marker checks
// against the expected waveform shape, for PRESCALE=1 and PRESCALE=4 instances.
`timescale 1ns/1ps
module tb_pwm_gen;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pwm_gen_if #(.WIDTH(8)) bus1 ();
    pwm_gen_if #(.WIDTH(8)) bus4 ();

    pwm_gen #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    pwm_gen #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #2.5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge whose next posedge begins a new period.
    // Expected shape: period_start on the first clk only, then exactly d
    // contiguous high clocks starting at the period start, then low.
    task automatic run_period(input int d, input int d_mid, input int change_at, input string tag);
        int   highs;
        int   first_low;
        int   ps_extra;
        logic ps0;
        highs     = 0;
        first_low = -1;
        ps_extra  = 0;
        ps0       = 1'b0;
        bus1.inpt = 8'(d);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) ps0 = bus1.period_start;
            else if (bus1.period_start === 1'b1) ps_extra++;
            if (bus1.outp === 1'b1) highs++;
            else if (first_low < 0) first_low = i;
            if (i == change_at) bus1.inpt = 8'(d_mid);
        end
        if (first_low < 0) first_low = 256;
        chk({tag, ".ps_first"}, 32'(ps0), 32'd1);
        chk({tag, ".ps_extra"}, ps_extra, 0);
        chk({tag, ".high_clks"}, highs, d);
        chk({tag, ".first_low"}, first_low, d);
        $display("period %s: duty=%0d high=%0d first_low=%0d", tag, d, highs, first_low);
    endtask

    initial begin
        int   sweep [5];
        int   d;
        int   dm;
        int   found;
        int   highs4;
        int   first_low4;
        int   ps_extra4;
        n_checks  = 0;
        n_fail    = 0;
        sweep     = '{1, 30, 90, 150, 200};
        rst_n     = 1'b0;
        bus1.inpt = 8'd0;
        bus4.inpt = 8'd128;

        // Held reset
        repeat (3) @(negedge clk);
        chk("reset.outp", 32'(bus1.outp), 32'd0);
        chk("reset.ps", 32'(bus1.period_start), 32'd0);
        chk("reset.outp4", 32'(bus4.outp), 32'd0);
        rst_n = 1'b1;

        // Zero duty: never high, period_start every 256 clk
        run_period(0, 0, -1, "zero_a");
        run_period(0, 0, -1, "zero_b");

        foreach (sweep[k]) run_period(sweep[k], sweep[k], -1, $sformatf("sweep%0d", sweep[k]));

        run_period(254, 254, -1, "d254");
        run_period(255, 255, -1, "d255");

        // Mid-period duty change only affects the following period
        run_period(30, 200, 100, "chg30");
        run_period(200, 200, -1, "chg200");

        for (int r = 0; r < 6; r++) begin
            d  = int'($urandom_range(255, 0));
            dm = int'($urandom_range(255, 0));
            run_period(d, dm, int'($urandom_range(254, 1)), $sformatf("rand%0d", r));
        end

        // Asynchronous reset pulse while outp and period_start are both high
        bus1.inpt = 8'd200;
        @(posedge clk);
        #1;
        chk("prerst.ps", 32'(bus1.period_start), 32'd1);
        chk("prerst.outp", 32'(bus1.outp), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.outp", 32'(bus1.outp), 32'd0);
        chk("async_rst.ps", 32'(bus1.period_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_period(200, 200, -1, "post_rst");

        // PRESCALE=4 instance: 1024-clk period, 512 high clocks
        found = 0;
        for (int i = 0; i < 2048 && found == 0; i++) begin
            @(negedge clk);
            if (bus4.period_start === 1'b1) found = 1;
        end
        chk("p4.found", found, 1);
        if (found == 1) begin
            highs4     = 0;
            first_low4 = -1;
            ps_extra4  = 0;
            for (int i = 0; i < 1024; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    if (bus4.period_start === 1'b1) ps_extra4++;
                end
                if (bus4.outp === 1'b1) highs4++;
                else if (first_low4 < 0) first_low4 = i;
            end
            @(negedge clk);
            chk("p4.high_clks", highs4, 512);
            chk("p4.first_low", first_low4, 512);
            chk("p4.ps_extra", ps_extra4, 0);
            chk("p4.ps_next", 32'(bus4.period_start), 32'd1);
            $display("period p4: duty=128 high=%0d first_low=%0d", highs4, first_low4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
